// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the FFT stage sequencer: state encoding and default sizing.
package fft_stage_sequencer_pkg;

  localparam int N_DEF  = 16;
  localparam int STAGES = $clog2(N_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    FILL_C,
    WRITE_REGS,
    CALC,
    CAPTURE,
    STREAM_OUT
  } seq_state_t;

endpackage

// File: rtl/fft_seq_buffer.sv
// N-word sample buffer: single-word write, full-width parallel capture, async read.
module fft_seq_buffer #(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [$clog2(N)-1:0] wr_addr_i,
  input  logic [MSB-1:0]       wr_data_i,
  input  logic                 cap_en_i,
  input  logic [N*MSB-1:0]     cap_data_i,
  input  logic [$clog2(N)-1:0] rd_addr_i,
  output logic [MSB-1:0]       rd_data_o
);

  logic [MSB-1:0] mem_q [N];

  // Capture of a whole stage result takes priority over a single-word write.
  always_ff @(posedge clk) begin
    if (cap_en_i) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= cap_data_i[i*MSB +: MSB];
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences one FFT transform: load N samples, run log2(N) datapath stages, stream results.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int MSB         = 16,
  parameter int FILL_CYCLES = N/2 + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MSB-1:0]         in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSB-1:0]         out_data,
  output logic                   fill_regs,
  output logic                   start_calc,
  output logic [MSB-1:0]         data_in,
  output logic [$clog2(N)-1:0]   addr_counter,
  output logic [$clog2(N/4)-1:0] stage,
  input  logic [N*MSB-1:0]       fft_data_out,
  input  logic                   calc_finish,
  output logic                   busy,
  output logic                   done
);

  localparam int AW   = $clog2(N);
  localparam int NSTG = $clog2(N);
  localparam int PW   = $clog2(N/4);
  localparam int SW0  = $clog2(NSTG);
  localparam int SW   = (PW > SW0) ? PW : SW0;
  localparam int FCW  = $clog2(FILL_CYCLES + 1);

  seq_state_t     state_q;
  logic [AW-1:0]  k_q;
  logic [SW-1:0]  stage_q;
  logic [FCW-1:0] fill_cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           fill_regs_q;
  logic           start_calc_q;
  logic           done_q;

  logic           wr_en;
  logic           cap_en;
  logic [MSB-1:0] rd_data;

  assign wr_en  = (state_q == LOAD_IN) && in_valid && in_ready_q;
  // A finish coincident with the start pulse belongs to no calculation of ours.
  assign cap_en = (state_q == CALC) && calc_finish && !start_calc_q;

  fft_seq_buffer #(
    .N   (N),
    .MSB (MSB)
  ) u_buf (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_addr_i  (k_q),
    .wr_data_i  (in_data),
    .cap_en_i   (cap_en),
    .cap_data_i (fft_data_out),
    .rd_addr_i  (k_q),
    .rd_data_o  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      stage_q      <= '0;
      fill_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      fill_regs_q  <= 1'b0;
      start_calc_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fill_regs_q  <= 1'b0;
      start_calc_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD_IN;
            k_q        <= '0;
            stage_q    <= '0;
            in_ready_q <= 1'b1;
          end
        end
        LOAD_IN: begin
          if (wr_en) begin
            if (k_q == AW'(N-1)) begin
              k_q         <= '0;
              state_q     <= FILL_C;
              in_ready_q  <= 1'b0;
              fill_regs_q <= 1'b1;
              fill_cnt_q  <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        FILL_C: begin
          if (fill_cnt_q == FCW'(FILL_CYCLES-1)) begin
            fill_cnt_q <= '0;
            k_q        <= '0;
            state_q    <= WRITE_REGS;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        WRITE_REGS: begin
          if (k_q == AW'(N-1)) begin
            k_q          <= '0;
            state_q      <= CALC;
            start_calc_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        CALC: begin
          if (cap_en) state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (stage_q == SW'(NSTG-1)) begin
            k_q         <= '0;
            state_q     <= STREAM_OUT;
            out_valid_q <= 1'b1;
          end else begin
            stage_q     <= stage_q + 1'b1;
            state_q     <= FILL_C;
            fill_regs_q <= 1'b1;
            fill_cnt_q  <= '0;
          end
        end
        STREAM_OUT: begin
          if (out_ready) begin
            if (k_q == AW'(N-1)) begin
              k_q         <= '0;
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign fill_regs    = fill_regs_q;
  assign start_calc   = start_calc_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign stage        = stage_q[PW-1:0];
  assign out_data     = (state_q == STREAM_OUT) ? rd_data : '0;
  assign data_in      = (state_q == WRITE_REGS) ? rd_data : '0;
  assign addr_counter = (state_q == WRITE_REGS) ? k_q : '0;

endmodule
